uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversampled start/data/stop framing with a
// valid/ready output holding register and framing/overrun flags.
// Ports:
//   clk, rst_n    - clock, async active-low reset
//   rx            - serial line (async, idle high)
//   baud_tick     - OVERSAMPLE x bit-rate strobe
//   count_en      - baud generator enable (high outside IDLE)
//   rx_data       - last delivered byte
//   rx_valid      - rx_data not yet consumed
//   rx_ready      - consumer accepts rx_data
//   framing_err   - pulse: stop bit sampled low
//   overrun       - pulse: completed byte dropped
//   parity_err    - pulse: even parity mismatch (UART_RX_PARITY_EN only)
//   busy          - controller outside IDLE
// Optional: define UART_RX_PARITY_EN to add one even-parity bit per frame.
module uart_rx_ctrl #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 baud_tick,
  output logic                 count_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 framing_err,
  output logic                 overrun,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  state_t state, nxt;

  logic                 rx_m, rx_s;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 brk;
  logic                 par_ok;
  logic                 mid_hit, end_hit;
  logic                 stop_evt, deliver;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  assign mid_hit  = baud_tick && (tick_cnt == T_HALF);
  assign end_hit  = baud_tick && (tick_cnt == T_LAST);
  assign stop_evt = (state == STOP) && end_hit;
  assign deliver  = stop_evt && rx_s && par_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        // brk blocks re-arming on a line still low after a framing error
        if (!rx_s && !brk) nxt = START;
      end
      START: begin
        if (mid_hit) nxt = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (end_hit && bit_cnt == B_LAST)
`ifdef UART_RX_PARITY_EN
          nxt = PARITY;
`else
          nxt = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (end_hit) nxt = STOP;
      end
`endif
      STOP: begin
        if (end_hit) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    count_en = 1'b0;
    busy     = 1'b0;
    if (state != IDLE) begin
      count_en = 1'b1;
      busy     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          tick_cnt <= '0;
          bit_cnt  <= '0;
        end
        START: begin
          if (mid_hit)        tick_cnt <= '0;
          else if (baud_tick) tick_cnt <= tick_cnt + 1'b1;
        end
        default: begin
          if (end_hit)        tick_cnt <= '0;
          else if (baud_tick) tick_cnt <= tick_cnt + 1'b1;
          if (state == DATA && end_hit) begin
            // LSB arrives first, so it ends up at bit 0
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_ok     <= 1'b1;
      parity_err <= 1'b0;
    end else begin
      parity_err <= stop_evt && !par_ok;
      if (state == PARITY && end_hit)
        par_ok <= (rx_s == ^shift);
    end
  end
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
      brk         <= 1'b0;
    end else begin
      framing_err <= stop_evt && !rx_s;
      overrun     <= 1'b0;
      if (stop_evt && !rx_s) brk <= 1'b1;
      else if (rx_s)         brk <= 1'b0;
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: framed bytes driven on rx with
// baud_tick held high (one bit = 16 clocks), outputs checked at negedge.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       baud_tick = 1'b1;
  logic       rx_ready = 1'b1;
  logic       count_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       framing_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_ctrl #(
    .OVERSAMPLE(16),
    .DATA_BITS (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .baud_tick  (baud_tick),
    .count_en   (count_en),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .framing_err(framing_err),
    .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int acc_cnt = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int perr_cnt = 0;
  bit saw_busy = 1'b0;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) acc_cnt++;
    if (framing_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) perr_cnt++;
`endif
    if (busy) saw_busy = 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_data(input logic [7:0] d);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_data(d);
    send_bit(^d);
    send_bit(stop);
  endtask
`else
  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_data(d);
    send_bit(stop);
  endtask
`endif

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_acc;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];
  int a0, f0, o0, p0;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 0, 1, 8'hA5};
    vecs[2] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[3] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[4] = '{8'h81, 1'b0, 0, 1, 8'hFF};
    vecs[5] = '{8'h5A, 1'b1, 1, 0, 8'h5A};

    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(rx_valid), 32'h0);
    chk("rst_data", 32'(rx_data), 32'h0);
    chk("rst_count_en", 32'(count_en), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ferr", 32'(framing_err), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    rst_n = 1'b1;
    idle(4);

    for (int i = 0; i < 6; i++) begin
      a0 = acc_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
      send_frame(vecs[i].data, vecs[i].stop);
      idle(6);
      chk($sformatf("v%0d_acc", i), 32'(acc_cnt - a0),
          32'(vecs[i].exp_acc));
      chk($sformatf("v%0d_ferr", i), 32'(ferr_cnt - f0),
          32'(vecs[i].exp_ferr));
      chk($sformatf("v%0d_ovr", i), 32'(ovr_cnt - o0), 32'h0);
      chk($sformatf("v%0d_data", i), 32'(rx_data),
          32'(vecs[i].exp_data));
      chk($sformatf("v%0d_count_en", i), 32'(count_en), 32'h0);
    end

    // short low pulse: start bit rejected at mid-bit
    a0 = acc_cnt; f0 = ferr_cnt;
    saw_busy = 1'b0;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    idle(30);
    chk("glitch_busy_seen", 32'(saw_busy), 32'h1);
    chk("glitch_acc", 32'(acc_cnt - a0), 32'h0);
    chk("glitch_ferr", 32'(ferr_cnt - f0), 32'h0);
    chk("glitch_busy_end", 32'(busy), 32'h0);

    // consumer stalled: second byte dropped with overrun
    rx_ready = 1'b0;
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b1);
    idle(6);
    chk("ovr_valid1", 32'(rx_valid), 32'h1);
    chk("ovr_data1", 32'(rx_data), 32'h11);
    send_frame(8'h22, 1'b1);
    idle(6);
    chk("ovr_pulse", 32'(ovr_cnt - o0), 32'h1);
    chk("ovr_data_kept", 32'(rx_data), 32'h11);
    chk("ovr_valid2", 32'(rx_valid), 32'h1);
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("ovr_drain", 32'(rx_valid), 32'h0);

    // break: line held low well past the stop bit
    a0 = acc_cnt; f0 = ferr_cnt;
    send_data(8'h00);
    rx = 1'b0;
    repeat (16 * 4 + 200) @(negedge clk);
    chk("brk_ferr_once", 32'(ferr_cnt - f0), 32'h1);
    chk("brk_busy", 32'(busy), 32'h0);
    chk("brk_acc", 32'(acc_cnt - a0), 32'h0);
    idle(20);
    send_frame(8'hC3, 1'b1);
    idle(6);
    chk("brk_after_data", 32'(rx_data), 32'hC3);
    chk("brk_after_acc", 32'(acc_cnt - a0), 32'h1);
    chk("brk_after_ferr", 32'(ferr_cnt - f0), 32'h1);

    // reset in the middle of a frame
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_count_en", 32'(count_en), 32'h0);
    chk("mrst_data", 32'(rx_data), 32'h0);
    rst_n = 1'b1;
    idle(3);
    a0 = acc_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'h5A, 1'b1);
    idle(6);
    chk("mrst_rx_data", 32'(rx_data), 32'h5A);
    chk("mrst_acc", 32'(acc_cnt - a0), 32'h1);
    chk("mrst_ferr", 32'(ferr_cnt - f0), 32'h0);
    chk("mrst_ovr", 32'(ovr_cnt - o0), 32'h0);

`ifdef UART_RX_PARITY_EN
    a0 = acc_cnt; p0 = perr_cnt;
    send_data(8'h07);
    send_bit(1'b0);
    send_bit(1'b1);
    idle(6);
    chk("par_bad_err", 32'(perr_cnt - p0), 32'h1);
    chk("par_bad_acc", 32'(acc_cnt - a0), 32'h0);
    chk("par_bad_data", 32'(rx_data), 32'h5A);
    a0 = acc_cnt; p0 = perr_cnt;
    send_data(8'h07);
    send_bit(1'b1);
    send_bit(1'b1);
    idle(6);
    chk("par_ok_err", 32'(perr_cnt - p0), 32'h0);
    chk("par_ok_acc", 32'(acc_cnt - a0), 32'h1);
    chk("par_ok_data", 32'(rx_data), 32'h07);
`else
    p0 = perr_cnt;
    chk("no_parity_err", 32'(perr_cnt - p0), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
